// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC byte writer: FSM states, the
// lead byte that defers output (0x0FF) and the initial buffered byte.
package cabac_pkg;

    typedef enum logic [1:0] {
        StAccept,
        StEmitBuf,
        StEmitRun
    } bw_state_e;

    localparam logic [8:0] LEAD_FF  = 9'h0FF;
    localparam logic [7:0] BUF_INIT = 8'hFF;

endpackage

// File: rtl/cabac_byte_writer_if.sv
// Handshake bundle between the arithmetic encoder, the byte writer and the
// bitstream sink. The writer uses the slave modport.
interface cabac_byte_writer_if;

    logic [8:0] lead_byte;
    logic       lead_valid;
    logic       lead_ready;
    logic       flush_req;
    logic       flush_carry;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       flush_done;
    logic       err_ovf;

    modport master (
        output lead_byte, lead_valid, flush_req, flush_carry, out_ready,
        input  lead_ready, out_byte, out_valid, flush_done, err_ovf
    );

    modport slave (
        input  lead_byte, lead_valid, flush_req, flush_carry, out_ready,
        output lead_ready, out_byte, out_valid, flush_done, err_ovf
    );

endinterface

// File: rtl/carry_byte_gen.sv
// Carry resolution for a deferred run: the buffered byte absorbs the carry,
// and every following deferred 0xFF byte wraps to 0x00 when the carry is set.
module carry_byte_gen (
    input  logic [7:0] buf_byte,
    input  logic       carry,
    output logic [7:0] first_byte,
    output logic [7:0] run_byte
);

    assign first_byte = buf_byte + {7'd0, carry};
    assign run_byte   = 8'hFF + {7'd0, carry};

endmodule

// File: rtl/cabac_byte_writer.sv
// CABAC output byte writer: buffers one byte plus a run of 0xFF leads until the
// carry is known, then emits the run. Define CABAC_BW_STATS_EN for byte_cnt.
module cabac_byte_writer
    import cabac_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef CABAC_BW_STATS_EN
    output logic [31:0] byte_cnt,
`endif
    cabac_byte_writer_if.slave bus
);

    localparam logic [CNT_W-1:0] NumMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NumOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] NumTwo = CNT_W'(2);

    bw_state_e        state_q, state_d;
    logic [7:0]       buf_q, buf_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             carry_q, carry_d;
    logic [7:0]       pend_q, pend_d;
    logic             flushing_q, flushing_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d;
    logic             flush_done_q, flush_done_d;
    logic             err_ovf_q, err_ovf_d;
    logic             armed_q;

    logic       lead_ready;
    logic       out_xfer;
    logic       run_done;
    logic       gen_carry;
    logic [7:0] first_byte;
    logic [7:0] run_byte;

    // armed_q keeps lead_ready low until the first edge after reset release.
    assign lead_ready = armed_q && (state_q == StAccept) && !out_valid_q;
    assign out_xfer   = out_valid_q && bus.out_ready;

    always_comb begin
        gen_carry = carry_q;
        if (state_q == StAccept) begin
            gen_carry = bus.flush_req ? bus.flush_carry : bus.lead_byte[8];
        end
    end

    carry_byte_gen u_carry_byte_gen (
        .buf_byte   (buf_q),
        .carry      (gen_carry),
        .first_byte (first_byte),
        .run_byte   (run_byte)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        num_d        = num_q;
        carry_d      = carry_q;
        pend_d       = pend_q;
        flushing_d   = flushing_q;
        out_byte_d   = out_byte_q;
        out_valid_d  = out_valid_q;
        flush_done_d = 1'b0;
        err_ovf_d    = err_ovf_q;
        run_done     = 1'b0;

        unique case (state_q)
            StAccept: begin
                if (lead_ready) begin
                    if (bus.flush_req) begin
                        if (num_q == '0) begin
                            flush_done_d = 1'b1;
                            buf_d        = BUF_INIT;
                        end else begin
                            carry_d     = bus.flush_carry;
                            flushing_d  = 1'b1;
                            out_byte_d  = first_byte;
                            out_valid_d = 1'b1;
                            state_d     = StEmitBuf;
                        end
                    end else if (bus.lead_valid) begin
                        if (bus.lead_byte == LEAD_FF) begin
                            if (num_q == NumMax) begin
                                err_ovf_d = 1'b1;
                            end else begin
                                num_d = num_q + NumOne;
                            end
                        end else if (num_q == '0) begin
                            buf_d = bus.lead_byte[7:0];
                            num_d = NumOne;
                        end else begin
                            carry_d     = bus.lead_byte[8];
                            pend_d      = bus.lead_byte[7:0];
                            flushing_d  = 1'b0;
                            out_byte_d  = first_byte;
                            out_valid_d = 1'b1;
                            state_d     = StEmitBuf;
                        end
                    end
                end
            end
            StEmitBuf: begin
                if (out_xfer) begin
                    if (num_q > NumOne) begin
                        state_d    = StEmitRun;
                        out_byte_d = run_byte;
                    end else begin
                        run_done = 1'b1;
                    end
                end
            end
            StEmitRun: begin
                // num_q counts the buffered byte too, so the run ends at 1.
                if (out_xfer) begin
                    num_d = num_q - NumOne;
                    if (num_q == NumTwo) begin
                        run_done = 1'b1;
                    end
                end
            end
            default: state_d = StAccept;
        endcase

        if (run_done) begin
            state_d     = StAccept;
            out_valid_d = 1'b0;
            if (flushing_q) begin
                buf_d        = BUF_INIT;
                num_d        = '0;
                flush_done_d = 1'b1;
            end else begin
                buf_d = pend_q;
                num_d = NumOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAccept;
            buf_q        <= BUF_INIT;
            num_q        <= '0;
            carry_q      <= 1'b0;
            pend_q       <= BUF_INIT;
            flushing_q   <= 1'b0;
            out_byte_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            num_q        <= num_d;
            carry_q      <= carry_d;
            pend_q       <= pend_d;
            flushing_q   <= flushing_d;
            out_byte_q   <= out_byte_d;
            out_valid_q  <= out_valid_d;
            flush_done_q <= flush_done_d;
            err_ovf_q    <= err_ovf_d;
            armed_q      <= 1'b1;
        end
    end

    assign bus.lead_ready = lead_ready;
    assign bus.out_byte   = out_byte_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.flush_done = flush_done_q;
    assign bus.err_ovf    = err_ovf_q;

`ifdef CABAC_BW_STATS_EN
    logic [31:0] byte_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
        end else if (out_xfer) begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
        end
    end

    assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_cabac_byte_writer.sv
// Scoreboard bench for cabac_byte_writer: a queue-based reference model predicts
// every output byte and flush_done pulse; a forked monitor pops and compares.
module tb_cabac_byte_writer;

    localparam logic [8:0] DONE  = 9'h100;
    localparam int         LIMIT = 2000;

    logic clk;
    logic rst_n;
    cabac_byte_writer_if bus ();
    cabac_byte_writer_if bus_s ();
`ifdef CABAC_BW_STATS_EN
    logic [31:0] byte_cnt;
    logic [31:0] byte_cnt_s;
`endif

    cabac_byte_writer #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CABAC_BW_STATS_EN
        .byte_cnt (byte_cnt),
`endif
        .bus      (bus)
    );

    cabac_byte_writer #(.CNT_W(2)) dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CABAC_BW_STATS_EN
        .byte_cnt (byte_cnt_s),
`endif
        .bus      (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  seen_q[$];
    logic [8:0]  want_q[$];
    logic [7:0]  m_buf;
    int          m_num;
    bit          rand_mode;
    bit          man_rdy;
    int unsigned xfers;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    // Reference model: a byte is held back with a count of trailing 0xFF leads;
    // a known carry releases buffered+carry followed by the run of 0xFF+carry.
    task automatic model_emit(input logic c);
        exp_q.push_back({1'b0, 8'((int'(m_buf) + int'(c)) % 256)});
        for (int i = 1; i < m_num; i++) exp_q.push_back({1'b0, 8'((255 + int'(c)) % 256)});
    endtask

    task automatic model_lead(input logic [8:0] b);
        if (b == 9'h0FF) begin
            if (m_num < 65535) m_num++;
        end else begin
            if (m_num > 0) model_emit(b[8]);
            m_buf = b[7:0];
            m_num = 1;
        end
    endtask

    task automatic model_flush(input logic c);
        if (m_num > 0) model_emit(c);
        m_buf = 8'hFF;
        m_num = 0;
        exp_q.push_back(DONE);
    endtask

    task automatic monitor_loop();
        bit         prev_stall = 1'b0;
        logic [7:0] prev_byte  = 8'h00;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                xfers = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_byte", 32'(bus.out_byte), 32'(prev_byte));
                end
                if (bus.out_valid && bus.out_ready) begin
                    xfers++;
                    seen_q.push_back({1'b0, bus.out_byte});
                    if (exp_q.size() == 0) fail_now("unexpected_out_byte");
                    else begin
                        e = exp_q.pop_front();
                        chk("out_byte", 32'({1'b0, bus.out_byte}), 32'(e));
                    end
                end
                if (bus.flush_done) begin
                    seen_q.push_back(DONE);
                    if (exp_q.size() == 0) fail_now("unexpected_flush_done");
                    else begin
                        e = exp_q.pop_front();
                        chk("flush_done", 32'(DONE), 32'(e));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_byte  = bus.out_byte;
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_mode ? ($urandom_range(3) != 0) : man_rdy;
        end
    endtask

    task automatic wait_ready(input string name, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < LIMIT) begin
            @(negedge clk);
            if (bus.lead_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) fail_now(name);
    endtask

    task automatic send_lead(input logic [8:0] b);
        bit ok;
        @(posedge clk); #1;
        bus.lead_byte  = b;
        bus.lead_valid = 1'b1;
        wait_ready("lead_wait", ok);
        if (ok) model_lead(b);
        @(posedge clk); #1;
        bus.lead_valid = 1'b0;
    endtask

    task automatic send_flush(input logic c);
        bit ok;
        @(posedge clk); #1;
        bus.flush_carry = c;
        bus.flush_req   = 1'b1;
        wait_ready("flush_wait", ok);
        if (ok) model_flush(c);
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
    endtask

    // Flush and lead together: flush wins, the lead stays pending.
    task automatic send_both(input logic [8:0] b, input logic c);
        bit ok;
        @(posedge clk); #1;
        bus.lead_byte   = b;
        bus.lead_valid  = 1'b1;
        bus.flush_carry = c;
        bus.flush_req   = 1'b1;
        wait_ready("both_wait", ok);
        if (ok) model_flush(c);
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        wait_ready("both_lead_wait", ok);
        if (ok) model_lead(b);
        @(posedge clk); #1;
        bus.lead_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) fail_now("idle_wait");
        @(posedge clk); #1;
    endtask

    task automatic check_seen(input string name);
        chk({name, "_len"}, 32'(seen_q.size()), 32'(want_q.size()));
        for (int i = 0; i < seen_q.size() && i < want_q.size(); i++) begin
            chk(name, 32'(seen_q[i]), 32'(want_q[i]));
        end
        seen_q.delete();
    endtask

    initial begin
        int acc;
        int n;
        logic [8:0] b;

        rst_n = 1'b0;
        bus.lead_byte = '0; bus.lead_valid = 1'b0;
        bus.flush_req = 1'b0; bus.flush_carry = 1'b0; bus.out_ready = 1'b1;
        bus_s.lead_byte = 9'h0FF; bus_s.lead_valid = 1'b0;
        bus_s.flush_req = 1'b0; bus_s.flush_carry = 1'b0; bus_s.out_ready = 1'b1;
        rand_mode = 1'b0; man_rdy = 1'b1; xfers = 0;
        m_buf = 8'hFF; m_num = 0;
        fork
            monitor_loop();
            ready_loop();
        join_none

        #23 rst_n = 1'b1;
        #1;
        chk("rst_lead_ready", 32'(bus.lead_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_byte", 32'(bus.out_byte), 32'd0);
        chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
        chk("rst_err_ovf", 32'(bus.err_ovf), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", 32'(bus.lead_ready), 32'd1);

        // Counter overflow on the CNT_W = 2 instance.
        bus_s.lead_valid = 1'b1;
        acc = 0; n = 0;
        while (acc < 3 && n < 100) begin
            @(negedge clk);
            if (bus_s.lead_ready) acc++;
            n++;
        end
        @(posedge clk); #1;
        bus_s.lead_valid = 1'b0;
        @(negedge clk);
        chk("ovf_before", 32'(bus_s.err_ovf), 32'd0);
        @(posedge clk); #1;
        bus_s.lead_valid = 1'b1;
        @(posedge clk); #1;
        bus_s.lead_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_after", 32'(bus_s.err_ovf), 32'd1);
        chk("ovf_no_output", 32'(bus_s.out_valid), 32'd0);

        // Directed sequences; a carry-0 flush exposes the buffered state.
        send_lead(9'h012); send_lead(9'h034); wait_idle();
        want_q = '{9'h012}; check_seen("seq_12_34");
        send_flush(1'b0); wait_idle();
        want_q = '{9'h034, DONE}; check_seen("seq_12_34_buf");

        send_lead(9'h012); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h105);
        wait_idle();
        want_q = '{9'h013, 9'h000, 9'h000}; check_seen("seq_carry_run");
        send_flush(1'b0); wait_idle();
        want_q = '{9'h005, DONE}; check_seen("seq_carry_run_buf");

        send_lead(9'h040); send_lead(9'h0FF); send_lead(9'h020); wait_idle();
        want_q = '{9'h040, 9'h0FF}; check_seen("seq_nocarry");
        send_flush(1'b0); wait_idle();
        want_q = '{9'h020, DONE}; check_seen("seq_nocarry_buf");

        send_lead(9'h07F); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h0FF);
        send_flush(1'b1); wait_idle();
        want_q = '{9'h080, 9'h000, 9'h000, 9'h000, DONE}; check_seen("flush_carry");
        send_flush(1'b0); wait_idle();
        want_q = '{DONE}; check_seen("flush_empty");

        // Back-pressure inside the 0xFF run.
        man_rdy = 1'b0;
        send_lead(9'h040); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h0FF);
        send_lead(9'h001);
        man_rdy = 1'b1;
        @(posedge clk); #1;
        man_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_byte", 32'(bus.out_byte), 32'h0FF);
            chk("stall_lead_ready", 32'(bus.lead_ready), 32'd0);
        end
        @(posedge clk); #1;
        man_rdy = 1'b1;
        wait_idle();
        want_q = '{9'h040, 9'h0FF, 9'h0FF, 9'h0FF}; check_seen("stall_run");
        send_flush(1'b0); wait_idle();
        seen_q.delete();

        // Flush/lead collision.
        send_lead(9'h055); send_lead(9'h0FF);
        send_both(9'h066, 1'b0); wait_idle();
        want_q = '{9'h055, 9'h0FF, DONE}; check_seen("prio_flush");
        send_flush(1'b0); wait_idle();
        want_q = '{9'h066, DONE}; check_seen("prio_lead_kept");

        // Reset in the middle of a run.
        man_rdy = 1'b0;
        send_lead(9'h040); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h001);
        man_rdy = 1'b1;
        @(posedge clk); #1;
        man_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_lead_ready", 32'(bus.lead_ready), 32'd0);
        chk("midrst_err_ovf_small", 32'(bus_s.err_ovf), 32'd0);
        exp_q.delete();
        m_buf = 8'hFF; m_num = 0;
        @(negedge clk);
        seen_q.delete();
        #2 rst_n = 1'b1;
        #1;
        chk("rel_lead_ready", 32'(bus.lead_ready), 32'd0);
        man_rdy = 1'b1;
        send_flush(1'b0); wait_idle();
        want_q = '{DONE}; check_seen("rst_num_zero");
        send_lead(9'h0FF); send_flush(1'b1); wait_idle();
        want_q = '{9'h000, DONE}; check_seen("rst_buf_ff");

        // Randomized traffic with random back-pressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(99));
            if (n < 8) begin
                send_flush(1'($urandom_range(1)));
            end else if (n < 12) begin
                send_both(9'($urandom_range(511)), 1'($urandom_range(1)));
            end else begin
                if ($urandom_range(2) == 0) b = 9'h0FF;
                else b = 9'($urandom_range(511));
                send_lead(b);
            end
        end
        send_flush(1'b0);
        wait_idle();
        seen_q.delete();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_err_ovf", 32'(bus.err_ovf), 32'd0);
`ifdef CABAC_BW_STATS_EN
        @(negedge clk);
        chk("byte_cnt", byte_cnt, 32'(xfers));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cabac_byte_writer.md
CABAC_BYTE_WRITER -- requirements
Module: cabac_byte_writer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the outstanding-byte counter.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: lead_byte  in  9  arithmetic-encoder lead byte, bit 8 = carry.
REQ-005 SHALL have ports: lead_valid  in  1 / lead_ready  out  1  lead-byte handshake.
REQ-006 SHALL have ports: flush_req  in  1 / flush_carry  in  1  end-of-slice flush, sampled when flush_req & lead_ready.
REQ-007 SHALL have ports: out_byte  out  8 / out_valid  out  1 / out_ready  in  1  bitstream byte handshake.
REQ-008 SHALL have ports: flush_done  out  1  one-cycle pulse; err_ovf  out  1  sticky counter-overflow flag.

Function
REQ-009 SHALL hold internal buf_byte (8 b) and num_buf (CNT_W b); a transfer occurs on valid & ready in the same cycle.
REQ-010 SHALL implement states ACCEPT, EMIT_BUF, EMIT_RUN; lead_ready = 1 only in ACCEPT with out_valid low.
REQ-011 SHALL, in ACCEPT on lead transfer with lead_byte == 9'h0FF, increment num_buf, emit nothing, stay in ACCEPT.
REQ-012 SHALL, on lead transfer with lead_byte != 9'h0FF and num_buf == 0, set buf_byte = lead_byte[7:0], num_buf = 1, emit nothing.
REQ-013 SHALL, on lead transfer with lead_byte != 9'h0FF and num_buf > 0, latch carry = lead_byte[8], go to EMIT_BUF presenting (buf_byte + carry) mod 256.
REQ-014 SHALL, leaving EMIT_BUF on out transfer, go to EMIT_RUN if num_buf > 1, else ACCEPT.
REQ-015 SHALL, in EMIT_RUN, present (8'hFF + carry) mod 256, decrementing num_buf per out transfer; return to ACCEPT when num_buf reaches 1.
REQ-016 SHALL, on entry to ACCEPT from a lead-triggered emission, hold buf_byte = latched lead_byte[7:0], num_buf = 1.
REQ-017 SHALL, on flush_req in ACCEPT, use flush_carry as carry and emit as REQ-013..015 when num_buf > 0; then set buf_byte = 8'hFF, num_buf = 0, pulse flush_done one cycle after last out transfer.
REQ-018 SHALL, on flush_req with num_buf == 0, pulse flush_done the next cycle with no output.
REQ-019 SHALL give flush_req priority over lead_valid when both asserted; lead is not consumed that cycle.
REQ-020 SHALL keep out_byte and out_valid stable while out_valid & !out_ready (one byte per cycle max throughput).
REQ-021 SHALL, if num_buf would increment past 2^CNT_W - 1, saturate num_buf and set err_ovf until reset.

Reset
REQ-022 SHALL on rst_n low asynchronously force: state ACCEPT, buf_byte 8'hFF, num_buf 0, out_byte 0, out_valid 0, flush_done 0, err_ovf 0.
REQ-023 SHALL discard any in-progress emission run when reset asserts mid-operation; no partial byte after release.
REQ-024 SHALL assert lead_ready no earlier than the first clk edge after rst_n deassertion.

Configuration
REQ-025 SHALL, with CABAC_BW_STATS_EN defined, add output byte_cnt (32 b) counting out transfers, reset 0, wrapping at 2^32.
REQ-026 SHALL, without CABAC_BW_STATS_EN, omit byte_cnt port and counter entirely; all other behaviour identical.

Structure
REQ-027 SHALL take state enum, LEAD_FF constant (9'h0FF) and BUF_INIT (8'hFF) from shared package cabac_pkg.
REQ-028 SHALL isolate the carry-add/run-byte generation in sub-module carry_byte_gen (combinational: buf_byte, carry -> first byte, run byte).

Verification
REQ-029 SHALL cover: leads 0x12, 0x34 with out_ready = 1 -> single out byte 0x12; buf_byte 0x34, num_buf 1.
REQ-030 SHALL cover: leads 0x12, 0xFF, 0xFF, 0x105 -> out 0x13, 0x00, 0x00; buf_byte 0x05, num_buf 1.
REQ-031 SHALL cover: leads 0x40, 0xFF, 0x020 -> out 0x40, 0xFF; buf_byte 0x20.
REQ-032 SHALL cover: out_ready low 5 cycles during EMIT_RUN -> out_byte stable, lead_ready 0, no byte lost or duplicated.
REQ-033 SHALL cover: buffered 0x7F + three 0xFF leads, flush_req with flush_carry 1 -> out 0x80, 0x00, 0x00, 0x00, then flush_done pulse; num_buf 0.
REQ-034 SHALL cover: rst_n low mid-EMIT_RUN -> out_valid 0 immediately, num_buf 0, buf_byte 0xFF; with CNT_W = 2, four 0xFF leads -> err_ovf 1.
